// File: rtl/vm_pkg.sv
// Shared types, status codes and coin decode for the vending machine transaction controller.
package vm_pkg;

    localparam int DEF_NSLOT  = 6;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_COST_W = 8;
    localparam int SLOT_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_e;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_SOLDOUT = 2'b01;
    localparam logic [1:0] ST_REFUSED = 2'b10;
    localparam logic [1:0] ST_VENDED  = 2'b11;

    function automatic logic [7:0] coin_value(input bit [1:0] code);
        case (code)
            2'b01:   return 8'd5;
            2'b10:   return 8'd10;
            2'b11:   return 8'd25;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_inventory.sv
// Per-slot (count, cost) register file: restock write port, decrement/restore port,
// combinational read of one slot.
module vm_inventory
    import vm_pkg::*;
#(
    parameter int NSLOT  = DEF_NSLOT,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int COST_W = DEF_COST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [CNT_W-1:0]  wr_count,
    input  logic [COST_W-1:0] wr_cost,
    input  logic              adj_en,
    input  logic              adj_inc,
    input  logic [SLOT_W-1:0] adj_slot,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [CNT_W-1:0]  rd_count,
    output logic [COST_W-1:0] rd_cost
);

    logic [CNT_W-1:0]  count_q [NSLOT];
    logic [COST_W-1:0] cost_q  [NSLOT];

    // NOTE: the table is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                count_q[i] <= '0;
                cost_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_en && wr_slot == SLOT_W'(i)) begin
                    count_q[i] <= wr_count;
                    cost_q[i]  <= wr_cost;
                end else if (adj_en && adj_slot == SLOT_W'(i)) begin
                    count_q[i] <= adj_inc ? count_q[i] + CNT_W'(1) : count_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_count = '0;
        rd_cost  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (rd_slot == SLOT_W'(i)) begin
                rd_count = count_q[i];
                rd_cost  = cost_q[i];
            end
        end
    end

endmodule

// File: rtl/vm_vend_sequencer.sv
// Vending transaction controller: coin credit, selection check, dispenser handshake
// with timeout, change return and restock arbitration.
module vm_vend_sequencer
    import vm_pkg::*;
#(
    parameter int NSLOT       = DEF_NSLOT,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int COST_W      = DEF_COST_W,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        coins,
    input  logic [NSLOT-1:0]  button,
    input  logic              cancel,
    input  logic              sup_valid,
    input  logic [2:0]        sup_slot,
    input  logic [CNT_W-1:0]  sup_count,
    input  logic [COST_W-1:0] sup_cost,
    output logic              sup_ready,
    output logic              disp_req,
    output logic [2:0]        disp_slot,
    input  logic              disp_ack,
    output logic [2:0]        product,
    output logic [1:0]        status,
    output logic [COST_W-1:0] balance,
    output logic [COST_W-1:0] change,
    output logic              change_valid,
    output logic              coin_reject
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [COST_W-1:0]   balance_q, balance_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [1:0]          status_q, status_d;
    logic [2:0]          product_q, product_d;
    logic [COST_W-1:0]   change_q, change_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;

    logic                btn_valid;
    logic [SLOT_W-1:0]   btn_slot;
    logic                coin_present;
    logic [COST_W:0]     coin_sum;
    logic                inv_wr_en, inv_adj_en, inv_adj_inc;
    logic [CNT_W-1:0]    rd_count;
    logic [COST_W-1:0]   rd_cost;

    always_comb begin
        btn_valid = ($countones(button) == 1);
        btn_slot  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (button[i]) btn_slot = SLOT_W'(i);
        end
    end

    assign coin_present = (coins != 2'b00);
    assign coin_sum     = {1'b0, balance_q} + {1'b0, COST_W'(coin_value(coins))};

    // Restock only when no credit is open and nothing from the user is pending this cycle.
    assign sup_ready = rst && (state_q == S_IDLE) && (balance_q == '0) && !btn_valid && !coin_present;
    assign inv_wr_en = sup_valid && sup_ready && (int'(sup_slot) < NSLOT);

    vm_inventory #(
        .NSLOT (NSLOT),
        .CNT_W (CNT_W),
        .COST_W(COST_W)
    ) u_inv (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inv_wr_en),
        .wr_slot (sup_slot),
        .wr_count(sup_count),
        .wr_cost (sup_cost),
        .adj_en  (inv_adj_en),
        .adj_inc (inv_adj_inc),
        .adj_slot(slot_q),
        .rd_slot (slot_q),
        .rd_count(rd_count),
        .rd_cost (rd_cost)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        balance_d      = balance_q;
        timer_d        = timer_q;
        status_d       = status_q;
        product_d      = '0;
        change_d       = '0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        inv_adj_en     = 1'b0;
        inv_adj_inc    = 1'b0;

        if (coin_present) begin
            if (state_q == S_IDLE && !coin_sum[COST_W]) balance_d = coin_sum[COST_W-1:0];
            else                                         coin_reject_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    if (balance_q != '0) state_d = S_CHANGE;
                end else if (btn_valid) begin
                    slot_d  = btn_slot;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (rd_count == '0) begin
                    status_d = ST_SOLDOUT;
                end else if (rd_cost == '0 || balance_q < rd_cost) begin
                    status_d = ST_REFUSED;
                end else begin
                    status_d   = ST_NONE;
                    inv_adj_en = 1'b1;
                    balance_d  = balance_q - rd_cost;
                    timer_d    = '0;
                    state_d    = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                // An ack in the final timeout cycle still completes the vend.
                if (disp_ack) begin
                    product_d = slot_q + 3'd1;
                    status_d  = ST_VENDED;
                    state_d   = (balance_q != '0) ? S_CHANGE : S_IDLE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    inv_adj_en  = 1'b1;
                    inv_adj_inc = 1'b1;
                    balance_d   = balance_q + rd_cost;
                    status_d    = ST_REFUSED;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CHANGE: begin
                change_d       = balance_q;
                change_valid_d = 1'b1;
                balance_d      = '0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            slot_q         <= '0;
            balance_q      <= '0;
            timer_q        <= '0;
            status_q       <= ST_NONE;
            product_q      <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            balance_q      <= balance_d;
            timer_q        <= timer_d;
            status_q       <= status_d;
            product_q      <= product_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign disp_req     = (state_q == S_DISPENSE);
    assign disp_slot    = disp_req ? slot_q : 3'd0;
    assign product      = product_q;
    assign status       = status_q;
    assign balance      = balance_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vm_vend_sequencer.sv
// Directed bench for vm_vend_sequencer: a coin/button vector table plus hand-written
// vend, refusal, arbitration, timeout and reset sequences.
module tb_vm_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coins = '0;
    logic [5:0] button = '0;
    logic       cancel = 1'b0;
    logic       sup_valid = 1'b0;
    logic [2:0] sup_slot = '0;
    logic [3:0] sup_count = '0;
    logic [7:0] sup_cost = '0;
    logic       sup_ready;
    logic       disp_req;
    logic [2:0] disp_slot;
    logic       disp_ack = 1'b0;
    logic [2:0] product;
    logic [1:0] status;
    logic [7:0] balance;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;

    int n_tests = 0;
    int n_fail  = 0;

    vm_vend_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .coins       (coins),
        .button      (button),
        .cancel      (cancel),
        .sup_valid   (sup_valid),
        .sup_slot    (sup_slot),
        .sup_count   (sup_count),
        .sup_cost    (sup_cost),
        .sup_ready   (sup_ready),
        .disp_req    (disp_req),
        .disp_slot   (disp_slot),
        .disp_ack    (disp_ack),
        .product     (product),
        .status      (status),
        .balance     (balance),
        .change      (change),
        .change_valid(change_valid),
        .coin_reject (coin_reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] coins;
        logic [5:0] button;
        logic [7:0] exp_bal;
        logic       exp_rej;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restock(input logic [2:0] slot, input logic [3:0] cnt, input logic [7:0] cost);
        sup_valid = 1'b1; sup_slot = slot; sup_count = cnt; sup_cost = cost;
        #1;
        check("restock_ready", sup_ready, 1);
        cycle();
        sup_valid = 1'b0;
    endtask

    task automatic insert(input logic [1:0] c);
        coins = c;
        cycle();
        coins = 2'b00;
    endtask

    task automatic press(input logic [5:0] b);
        button = b;
        cycle();
        button = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b01, 6'b000000, 8'd5,   1'b0};
        vecs[1]  = '{2'b10, 6'b000000, 8'd15,  1'b0};
        vecs[2]  = '{2'b11, 6'b000000, 8'd40,  1'b0};
        vecs[3]  = '{2'b00, 6'b000110, 8'd40,  1'b0};
        vecs[4]  = '{2'b00, 6'b111111, 8'd40,  1'b0};
        for (int i = 0; i < 8; i++) vecs[5 + i] = '{2'b11, 6'b000000, 8'(65 + 25 * i), 1'b0};
        vecs[13] = '{2'b11, 6'b000000, 8'd240, 1'b1};
        vecs[14] = '{2'b10, 6'b000000, 8'd250, 1'b0};
        vecs[15] = '{2'b01, 6'b000000, 8'd255, 1'b0};
        vecs[16] = '{2'b01, 6'b000000, 8'd255, 1'b1};
        vecs[17] = '{2'b11, 6'b000000, 8'd255, 1'b1};

        // Reset state
        cycle(); cycle();
        check("rst_sup_ready", sup_ready, 0);
        check("rst_disp_req", disp_req, 0);
        check("rst_balance", balance, 0);
        check("rst_status", status, 0);
        check("rst_product", product, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_coin_reject", coin_reject, 0);
        rst = 1'b1;
        cycle();
        check("idle_sup_ready", sup_ready, 1);

        // Coin accumulation, ignored button patterns and overflow rejection
        for (int i = 0; i < 18; i++) begin
            coins = vecs[i].coins; button = vecs[i].button;
            cycle();
            coins = 2'b00; button = '0;
            check($sformatf("vec%0d_balance", i), balance, vecs[i].exp_bal);
            check($sformatf("vec%0d_coin_reject", i), coin_reject, vecs[i].exp_rej);
            check($sformatf("vec%0d_status", i), status, 0);
            check($sformatf("vec%0d_disp_req", i), disp_req, 0);
        end
        cancel = 1'b1; cycle(); cancel = 1'b0;
        cycle();
        check("cancel255_change_valid", change_valid, 1);
        check("cancel255_change", change, 255);
        check("cancel255_balance", balance, 0);

        // Out-of-range restock slot still completes the handshake
        restock(3'd7, 4'd9, 8'd9);

        // Normal vend
        restock(3'd2, 4'd3, 8'd15);
        insert(2'b10); insert(2'b10);
        check("vend_balance_in", balance, 20);
        press(6'b000100);
        check("vend_check_no_req", disp_req, 0);
        cycle();
        check("vend_disp_req", disp_req, 1);
        check("vend_disp_slot", disp_slot, 2);
        check("vend_balance_debit", balance, 5);
        disp_ack = 1'b1; cycle(); disp_ack = 1'b0;
        check("vend_product", product, 3);
        check("vend_status", status, 2'b11);
        check("vend_no_req_after_ack", disp_req, 0);
        cycle();
        check("vend_change_valid", change_valid, 1);
        check("vend_change", change, 5);
        check("vend_balance_zero", balance, 0);
        check("vend_product_pulse", product, 0);
        check("vend_count", dut.u_inv.count_q[2], 2);
        cycle();
        check("vend_change_strobe", change_valid, 0);
        check("vend_status_hold", status, 2'b11);

        // Zero-cost slot is refused
        restock(3'd4, 4'd1, 8'd0);
        insert(2'b01);
        press(6'b010000);
        cycle();
        check("cost0_status", status, 2'b10);
        check("cost0_balance", balance, 5);

        // Arbitration and multi-press with open credit
        sup_valid = 1'b1; sup_slot = 3'd3; sup_count = 4'd7; sup_cost = 8'd20;
        #1;
        check("arb_stall_bal5", sup_ready, 0);
        cycle();
        insert(2'b10);
        check("multi_balance_in", balance, 15);
        press(6'b000110);
        check("multi_balance", balance, 15);
        check("multi_status", status, 2'b10);
        check("multi_disp_req", disp_req, 0);
        check("arb_stall_bal15", sup_ready, 0);
        cancel = 1'b1; cycle(); cancel = 1'b0;
        check("arb_stall_change_state", sup_ready, 0);
        cycle();
        check("cancel_change_valid", change_valid, 1);
        check("cancel_change", change, 15);
        check("cancel_balance", balance, 0);
        check("arb_ready_after_change", sup_ready, 1);
        cycle();
        sup_valid = 1'b0;
        check("arb_write_count", dut.u_inv.count_q[3], 7);
        check("arb_write_cost", dut.u_inv.cost_q[3], 20);

        // Sold out and insufficient funds
        restock(3'd1, 4'd2, 8'd30);
        insert(2'b11);
        press(6'b000001);
        cycle();
        check("soldout_status", status, 2'b01);
        check("soldout_balance", balance, 25);
        press(6'b000010);
        check("funds_check_no_req", disp_req, 0);
        cycle();
        check("funds_status", status, 2'b10);
        check("funds_balance", balance, 25);
        check("funds_no_req", disp_req, 0);

        // Timeout with no ack restores count and balance
        press(6'b000100);
        cycle();
        check("tmo_disp_req", disp_req, 1);
        check("tmo_count_debit", dut.u_inv.count_q[2], 1);
        begin
            int held = 0;
            for (int i = 0; i < 14; i++) begin
                if (i == 3) insert(2'b01);
                else        cycle();
                if (disp_req) held++;
            end
            check("tmo_req_held", held, 14);
            check("tmo_coin_ignored", balance, 10);
        end
        cycle();
        check("tmo_req_drop", disp_req, 0);
        check("tmo_status", status, 2'b10);
        check("tmo_balance", balance, 25);
        check("tmo_count", dut.u_inv.count_q[2], 2);

        // Ack in the same cycle as the timeout counts as an ack
        press(6'b000100);
        cycle();
        for (int i = 0; i < 14; i++) cycle();
        check("late_ack_req", disp_req, 1);
        disp_ack = 1'b1; cycle(); disp_ack = 1'b0;
        check("late_ack_product", product, 3);
        check("late_ack_status", status, 2'b11);
        cycle();
        check("late_ack_change", change, 10);
        check("late_ack_change_valid", change_valid, 1);
        check("late_ack_count", dut.u_inv.count_q[2], 1);

        // Async reset mid-dispense
        insert(2'b11);
        press(6'b000100);
        cycle();
        check("rstd_disp_req_before", disp_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rstd_disp_req", disp_req, 0);
        check("rstd_balance", balance, 0);
        check("rstd_status", status, 0);
        check("rstd_product", product, 0);
        check("rstd_change", change, 0);
        check("rstd_change_valid", change_valid, 0);
        check("rstd_sup_ready", sup_ready, 0);
        check("rstd_count", dut.u_inv.count_q[2], 0);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check("rstd_recover_ready", sup_ready, 1);
        check("rstd_recover_req", disp_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vm_vend_sequencer.md
# vm_vend_sequencer

Transaction controller for the six-slot vending machine. It accumulates coins and validates the one-hot selection button. It checks stock and price against a per-slot inventory table and sequences a request/acknowledge handshake with the dispenser, then returns change. It also shares the inventory table between user vends and supplier restock writes, giving the user priority while a credit is open.

## Interface
- NSLOT, 6, number of product slots
- CNT_W, 4, per-slot item count width
- COST_W, 8, cost and balance width
- ACK_TIMEOUT, 15, cycles to wait for disp_ack before aborting a vend
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous assert, active-low; synchronous deassert handled upstream
- coins  in  2  coin event per cycle: 00 none, 01 = 5, 10 = 10, 11 = 25
- button  in  NSLOT  selection buttons, level
- cancel  in  1  return credit request
- sup_valid  in  1  restock write request
- sup_slot  in  3  slot index 0..NSLOT-1
- sup_count, sup_cost  in  CNT_W, COST_W  new count and cost for sup_slot
- sup_ready  out  1  restock accepted this cycle when sup_valid is high
- disp_req  out  1  dispense request, held until ack or timeout
- disp_slot  out  3  slot being dispensed
- disp_ack  in  1  dispenser done
- product  out  3  slot+1 for one cycle on successful vend, else 0
- status  out  2  00 none, 01 sold out, 10 refused (funds, invalid slot, timeout), 11 vended
- balance  out  COST_W  current credit
- change  out  COST_W, change_valid  out  1  change amount, one-cycle strobe
- coin_reject  out  1  one-cycle pulse when a coin is refused

## Operation
- States: IDLE, CHECK, DISPENSE, CHANGE.
- IDLE:
  - Coins add to balance. If the sum exceeds 255, or the state is not IDLE, pulse coin_reject and leave balance unchanged.
  - A button vector with popcount exactly 1 latches the slot and moves to CHECK. Zero or multiple bits are ignored, with no status change.
  - cancel with balance>0 moves to CHANGE. cancel and a valid button in the same cycle: cancel wins.
- Restock arbitration:
  - sup_ready = IDLE && balance==0 && no valid button && no coin.
  - On sup_valid&&sup_ready, write count and cost into sup_slot. A slot ≥ NSLOT is dropped silently, but the handshake still completes.
  - While balance>0, supplier writes are stalled.
- CHECK (1 cycle):
  - count==0: status=01, go to IDLE, balance kept.
  - balance<cost, or cost==0: status=10, go to IDLE.
  - Otherwise: count−1, balance−=cost, go to DISPENSE.
- DISPENSE:
  - disp_req=1 and disp_slot=latched slot.
  - On disp_ack: product=slot+1 and status=11. Go to CHANGE if balance>0, else IDLE.
  - After ACK_TIMEOUT cycles with no ack: restore count+1 and balance+=cost, status=10, go to IDLE.
  - Coins and cancel are ignored in DISPENSE; coins are rejected.
- CHANGE (1 cycle): change=balance, change_valid=1, balance←0, go to IDLE.
- status holds until the next CHECK or reset.

## Timing
- Reset:
  - state IDLE; all counts and costs 0.
  - balance, change, product, status all 0.
  - change_valid, disp_req, sup_ready, coin_reject all 0.
  - Reset during DISPENSE drops disp_req immediately and discards the transaction.
- Vend timeline:
  - Button sampled at edge N: CHECK during N+1; disp_req high from N+2.
  - disp_ack sampled at edge M: product and status valid in cycle M+1, for one cycle.
  - change_valid in cycle M+2 when balance>0.
- Coin sampled at edge N: balance updated in cycle N+1.
- Restock write is visible to a CHECK beginning the next cycle.
- A disp_ack arriving in the same cycle as the timeout counts as an ack.
- Balance arithmetic is COST_W bits, with no wrap: overflow is prevented by the coin-reject rule.

## Structure
- vm_pkg holds:
  - the state enum;
  - status codes (ST_NONE, ST_SOLDOUT, ST_REFUSED, ST_VENDED);
  - coin decode function coin_value(bit [1:0]);
  - NSLOT, CNT_W and COST_W defaults.
- Sub-module vm_inventory holds the NSLOT×(count, cost) register file. Ports:
  - one write port for restock;
  - one decrement/restore port;
  - combinational read of the selected slot.
- The FSM, balance register and timeout counter stay in vm_vend_sequencer.

## Test plan
- **Normal vend:** restock slot 2 with count=3, cost=15; insert 10, 10; press button=6'b000100. Required: disp_req with disp_slot=2; ack; then product=3, status=11, change=5 with change_valid, count=2, balance=0.
- **Sold out and funds:**
  - Slot 0 with count=0, balance 25: status=01, balance stays 25.
  - Slot 1 with cost=30, balance 25: status=10, no disp_req.
- **Multi-press and cancel:** button=6'b000110 gives no state change. Then cancel with balance=15 gives change=15 and balance=0.
- **Arbitration:** sup_valid while balance=5 keeps sup_ready=0. After cancel and change, sup_ready=1 and the write lands.
- **Timeout and overflow:**
  - No disp_ack for 15 cycles: status=10, count and balance restored.
  - Balance 240 plus coin 11 (25): coin_reject pulse, balance stays 240.
- **Async reset mid-DISPENSE:** disp_req drops within the same cycle, and all outputs read 0.
